// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared definitions for the regfile_2r1w_p register file:
//               an address-width helper that never returns less than one bit,
//               and the data value returned by a read that misses (invalid
//               entry, out-of-range address).
// Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    // Ceiling log2 with a floor of 1 so that a DEPTH of 1 or 2 still yields a
    // usable one-bit address bus.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Data presented on a read port whenever the entry is not readable.
    localparam int unsigned RD_MISS_DATA = 0;

endpackage
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rd_port
// Description : One registered read port of the register file. Selects the
//               entry addressed by rd_addr_i as it will stand after the
//               current edge's clr/write update (write-first bypass), masks
//               invalid and out-of-range entries to zero, and applies the
//               optional hard-wired zero register on entry 0.
// Revision    : 1.0  initial release
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   mem_i      in   storage snapshot, DEPTH x DATA_W
//   valid_i    in   per-entry valid snapshot
//   wr_fire_i  in   qualified write (in range, not the zero register)
//   wr_addr_i  in   write address
//   wr_data_i  in   write data
//   clr_i      in   invalidate-all command
//   rd_en_i    in   read enable; outputs hold while low
//   rd_addr_i  in   read address
//   rd_data_o  out  registered read data
//   rd_valid_o out  registered valid flag of the entry read
// ============================================================================
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = clog2_min1(DEPTH),
    parameter int ZERO_REG0 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] mem_i [DEPTH],
    input  logic [DEPTH-1:0]  valid_i,
    input  logic              wr_fire_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              clr_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o
);

    localparam logic [DATA_W-1:0] MISS_DATA = DATA_W'(RD_MISS_DATA);

    logic              w_in_range;
    logic              w_zero_hit;
    logic              w_wr_hit;
    logic [ADDR_W-1:0] w_idx;
    logic [DATA_W-1:0] rd_data_d;
    logic              rd_valid_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    assign w_in_range = (int'(rd_addr_i) < DEPTH);
    assign w_zero_hit = (ZERO_REG0 != 0) && (rd_addr_i == '0);
    // wr_fire_i is already range- and zero-register-qualified, so an address
    // match alone means this edge's write lands in the entry being read.
    assign w_wr_hit   = wr_fire_i && (wr_addr_i == rd_addr_i);
    // Keep the array index inside the declared range when DEPTH is not a
    // power of two; the result is masked by w_in_range anyway.
    assign w_idx      = w_in_range ? rd_addr_i : '0;

    always_comb begin
        rd_data_d  = MISS_DATA;
        rd_valid_d = 1'b0;
        if (w_zero_hit) begin
            rd_data_d  = MISS_DATA;
            rd_valid_d = 1'b1;
        end else if (!w_in_range) begin
            rd_data_d  = MISS_DATA;
            rd_valid_d = 1'b0;
        end else if (w_wr_hit) begin
            // The write applies after clr, so it wins over a same-cycle clr.
            rd_data_d  = wr_data_i;
            rd_valid_d = 1'b1;
        end else if (clr_i) begin
            rd_data_d  = MISS_DATA;
            rd_valid_d = 1'b0;
        end else if (valid_i[w_idx]) begin
            rd_data_d  = mem_i[w_idx];
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (rd_en_i) begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule
`default_nettype wire

// File: rtl/regfile_2r1w_p.sv
`default_nettype none
// ============================================================================
// Module      : regfile_2r1w_p
// Description : Parametrised register file, one write port and two
//               independent registered read ports with write-first bypass.
//               Per-entry valid flags, a global invalidate (clr) and an
//               optional hard-wired zero register at entry 0.
// Revision    : 1.0  initial release
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   wr_en      in   write enable
//   wr_addr    in   write address (>= DEPTH ignored)
//   wr_data    in   write data
//   clr        in   invalidate all entries; a same-cycle write survives
//   rd_en0/1   in   read enable per port; outputs hold while low
//   rd_addr0/1 in   read address per port
//   rd_data0/1 out  registered read data (0 on a miss)
//   rd_valid0/1 out registered valid flag of the entry read
// ============================================================================
module regfile_2r1w_p
    import regfile_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = clog2_min1(DEPTH),
    parameter int ZERO_REG0 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr,
    input  logic              rd_en0,
    input  logic [ADDR_W-1:0] rd_addr0,
    output logic [DATA_W-1:0] rd_data0,
    output logic              rd_valid0,
    input  logic              rd_en1,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    output logic              rd_valid1
);

    logic [DATA_W-1:0] mem_q   [DEPTH];
    logic [DATA_W-1:0] mem_d   [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic              w_wr_fire;

    // A write only takes effect inside the array and never on a hard-wired
    // zero register.
    assign w_wr_fire = wr_en
                       && (int'(wr_addr) < DEPTH)
                       && !((ZERO_REG0 != 0) && (wr_addr == '0));

    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        // clr first, then the write, so the written entry ends valid.
        if (clr) begin
            valid_d = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_fire && (wr_addr == ADDR_W'(i))) begin
                mem_d[i]   = wr_data;
                valid_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            mem_q   <= mem_d;
            valid_q <= valid_d;
        end
    end

    regfile_rd_port #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .ZERO_REG0 (ZERO_REG0)
    ) u_rd_port0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_i      (mem_q),
        .valid_i    (valid_q),
        .wr_fire_i  (w_wr_fire),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .clr_i      (clr),
        .rd_en_i    (rd_en0),
        .rd_addr_i  (rd_addr0),
        .rd_data_o  (rd_data0),
        .rd_valid_o (rd_valid0)
    );

    regfile_rd_port #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .ZERO_REG0 (ZERO_REG0)
    ) u_rd_port1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_i      (mem_q),
        .valid_i    (valid_q),
        .wr_fire_i  (w_wr_fire),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .clr_i      (clr),
        .rd_en_i    (rd_en1),
        .rd_addr_i  (rd_addr1),
        .rd_data_o  (rd_data1),
        .rd_valid_o (rd_valid1)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_2r1w_p
// Description : Testbench for regfile_2r1w_p. Unit 0 is DATA_W=8, DEPTH=4,
//               no zero register; unit 1 is DATA_W=8, DEPTH=3, ZERO_REG0=1.
//               An array-based reference model predicts every read.
// Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_2r1w_p;

    logic       clk;
    logic       rst_n;
    logic       we  [2];
    logic [1:0] wa  [2];
    logic [7:0] wd  [2];
    logic       cl  [2];
    logic       re0 [2];
    logic [1:0] ra0 [2];
    logic       re1 [2];
    logic [1:0] ra1 [2];
    logic [7:0] rd0 [2];
    logic       rv0 [2];
    logic [7:0] rd1 [2];
    logic       rv1 [2];

    // Reference model state and expected outputs
    logic [7:0] mm  [2][4];
    logic       mv  [2][4];
    logic [7:0] ed0 [2];
    logic       ev0 [2];
    logic [7:0] ed1 [2];
    logic       ev1 [2];

    int checks;
    int failures;

    regfile_2r1w_p #(.DATA_W(8), .DEPTH(4), .ZERO_REG0(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(we[0]), .wr_addr(wa[0]), .wr_data(wd[0]), .clr(cl[0]),
        .rd_en0(re0[0]), .rd_addr0(ra0[0]), .rd_data0(rd0[0]), .rd_valid0(rv0[0]),
        .rd_en1(re1[0]), .rd_addr1(ra1[0]), .rd_data1(rd1[0]), .rd_valid1(rv1[0])
    );

    regfile_2r1w_p #(.DATA_W(8), .DEPTH(3), .ZERO_REG0(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(we[1]), .wr_addr(wa[1]), .wr_data(wd[1]), .clr(cl[1]),
        .rd_en0(re0[1]), .rd_addr0(ra0[1]), .rd_data0(rd0[1]), .rd_valid0(rv0[1]),
        .rd_en1(re1[1]), .rd_addr1(ra1[1]), .rd_data1(rd1[1]), .rd_valid1(rv1[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 4; i++) begin
                mm[u][i] = 8'h00;
                mv[u][i] = 1'b0;
            end
            ed0[u] = 8'h00; ev0[u] = 1'b0;
            ed1[u] = 8'h00; ev1[u] = 1'b0;
        end
    endtask

    function automatic int depth_of(int u);
        return (u == 1) ? 3 : 4;
    endfunction

    task automatic model_read(input int u, input int a, output logic [7:0] d, output logic v);
        if (u == 1 && a == 0) begin
            d = 8'h00; v = 1'b1;
        end else if (a >= depth_of(u)) begin
            d = 8'h00; v = 1'b0;
        end else if (mv[u][a]) begin
            d = mm[u][a]; v = 1'b1;
        end else begin
            d = 8'h00; v = 1'b0;
        end
    endtask

    // One clock for unit u: drive, clock, update model, return inputs to idle.
    task automatic cyc(input int u, input logic w, input logic [1:0] a, input logic [7:0] d,
                       input logic c, input logic e0, input logic [1:0] a0,
                       input logic e1, input logic [1:0] a1);
        we[u] = w; wa[u] = a; wd[u] = d; cl[u] = c;
        re0[u] = e0; ra0[u] = a0; re1[u] = e1; ra1[u] = a1;
        @(posedge clk);
        if (c) begin
            for (int i = 0; i < 4; i++) mv[u][i] = 1'b0;
        end
        if (w && int'(a) < depth_of(u) && !(u == 1 && a == 2'd0)) begin
            mm[u][a] = d;
            mv[u][a] = 1'b1;
        end
        if (e0) model_read(u, int'(a0), ed0[u], ev0[u]);
        if (e1) model_read(u, int'(a1), ed1[u], ev1[u]);
        #1;
        we[u] = 1'b0; cl[u] = 1'b0; re0[u] = 1'b0; re1[u] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1;
        for (int u = 0; u < 2; u++) begin
            we[u] = 0; wa[u] = 0; wd[u] = 0; cl[u] = 0;
            re0[u] = 0; ra0[u] = 0; re1[u] = 0; ra1[u] = 0;
        end
        #1 rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (rd0[u] !== 8'h00 || rv0[u] !== 1'b0 || rd1[u] !== 8'h00 || rv1[u] !== 1'b0) begin
                failures++;
                $display("FAIL reset u%0d: got d0=%h v0=%b d1=%h v1=%b, need all zero",
                         u, rd0[u], rv0[u], rd1[u], rv1[u]);
            end
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_invalid();
        cyc(0, 0, 0, 0, 0, 1, 2'd2, 0, 0);
        checks++;
        if (rd0[0] !== 8'h00 || rv0[0] !== 1'b0) begin
            failures++;
            $display("FAIL read_invalid: got d=%h v=%b, need d=00 v=0", rd0[0], rv0[0]);
        end
    endtask

    task automatic test_write_read();
        cyc(0, 1, 2'd1, 8'hA5, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 2'd1, 1, 2'd1);
        checks++;
        if (rd0[0] !== 8'hA5 || rv0[0] !== 1'b1) begin
            failures++;
            $display("FAIL write_read p0: got d=%h v=%b, need d=a5 v=1", rd0[0], rv0[0]);
        end
        checks++;
        if (rd1[0] !== 8'hA5 || rv1[0] !== 1'b1) begin
            failures++;
            $display("FAIL write_read p1: got d=%h v=%b, need d=a5 v=1", rd1[0], rv1[0]);
        end
    endtask

    task automatic test_bypass();
        cyc(0, 1, 2'd3, 8'h3C, 0, 1, 2'd3, 1, 2'd3);
        checks++;
        if (rd1[0] !== 8'h3C || rv1[0] !== 1'b1) begin
            failures++;
            $display("FAIL bypass p1: got d=%h v=%b, need d=3c v=1", rd1[0], rv1[0]);
        end
        checks++;
        if (rd0[0] !== rd1[0] || rv0[0] !== rv1[0]) begin
            failures++;
            $display("FAIL bypass p0: got d=%h v=%b, need d=%h v=%b", rd0[0], rv0[0], rd1[0], rv1[0]);
        end
    endtask

    task automatic test_hold();
        cyc(0, 1, 2'd3, 8'h77, 0, 0, 0, 0, 0);
        checks++;
        if (rd1[0] !== ed1[0] || rv1[0] !== ev1[0]) begin
            failures++;
            $display("FAIL hold p1: got d=%h v=%b, need d=%h v=%b", rd1[0], rv1[0], ed1[0], ev1[0]);
        end
    endtask

    task automatic test_clr_write();
        for (int i = 0; i < 4; i++) cyc(0, 1, 2'(i), 8'(8'h50 + i), 0, 0, 0, 0, 0);
        cyc(0, 1, 2'd2, 8'h11, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 2'd1, 1, 2'd2);
        checks++;
        if (rd0[0] !== 8'h00 || rv0[0] !== 1'b0) begin
            failures++;
            $display("FAIL clr_write addr1: got d=%h v=%b, need d=00 v=0", rd0[0], rv0[0]);
        end
        checks++;
        if (rd1[0] !== 8'h11 || rv1[0] !== 1'b1) begin
            failures++;
            $display("FAIL clr_write addr2: got d=%h v=%b, need d=11 v=1", rd1[0], rv1[0]);
        end
    endtask

    task automatic test_zero_reg_range();
        cyc(1, 1, 2'd0, 8'hFF, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 2'd0, 0, 0);
        checks++;
        if (rd0[1] !== 8'h00 || rv0[1] !== 1'b1) begin
            failures++;
            $display("FAIL zero_reg: got d=%h v=%b, need d=00 v=1", rd0[1], rv0[1]);
        end
        cyc(1, 1, 2'd1, 8'h21, 0, 0, 0, 0, 0);
        cyc(1, 1, 2'd2, 8'h42, 0, 0, 0, 0, 0);
        cyc(1, 1, 2'd3, 8'hEE, 0, 1, 2'd3, 0, 0);
        checks++;
        if (rd0[1] !== 8'h00 || rv0[1] !== 1'b0) begin
            failures++;
            $display("FAIL out_of_range: got d=%h v=%b, need d=00 v=0", rd0[1], rv0[1]);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0, 1, 2'(i), 1, 2'(i));
            checks++;
            if (rd0[1] !== ed0[1] || rv0[1] !== ev0[1] || rd1[1] !== ed1[1] || rv1[1] !== ev1[1]) begin
                failures++;
                $display("FAIL range_untouched a%0d: got d0=%h v0=%b d1=%h v1=%b, need d=%h v=%b",
                         i, rd0[1], rv0[1], rd1[1], rv1[1], ed0[1], ev0[1]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int u;
            u = n % 2;
            cyc(u, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                ($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            checks++;
            if (rd0[u] !== ed0[u] || rv0[u] !== ev0[u]) begin
                failures++;
                $display("FAIL random p0 u%0d n%0d: got d=%h v=%b, need d=%h v=%b",
                         u, n, rd0[u], rv0[u], ed0[u], ev0[u]);
            end
            checks++;
            if (rd1[u] !== ed1[u] || rv1[u] !== ev1[u]) begin
                failures++;
                $display("FAIL random p1 u%0d n%0d: got d=%h v=%b, need d=%h v=%b",
                         u, n, rd1[u], rv1[u], ed1[u], ev1[u]);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) cyc(0, 1, 2'(i), 8'(8'h90 + i), 0, 1, 2'(i), 1, 2'(i));
        // Drop reset away from any clock edge with reads idle.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (rd0[0] !== 8'h00 || rv0[0] !== 1'b0 || rd1[0] !== 8'h00 || rv1[0] !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got d0=%h v0=%b d1=%h v1=%b, need all zero",
                     rd0[0], rv0[0], rd1[0], rv1[0]);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 2'(i), 1, 2'(3 - i));
            checks++;
            if (rv0[0] !== 1'b0 || rd0[0] !== 8'h00 || rv1[0] !== 1'b0 || rd1[0] !== 8'h00) begin
                failures++;
                $display("FAIL post_reset a%0d: got d0=%h v0=%b d1=%h v1=%b, need all zero",
                         i, rd0[0], rv0[0], rd1[0], rv1[0]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_read_invalid();
        test_write_read();
        test_bypass();
        test_hold();
        test_clr_write();
        test_zero_reg_range();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_2r1w_p.md
Name: regfile_2r1w_p

Overview:
Parametrised register file with one write port and two independent read ports, generalising the 4x4 1R1W file to arbitrary width and depth.
- Read ports are registered (1-cycle latency) with write-first bypass.
- Per-entry valid flags, a global invalidate command and an optional hard-wired zero register.
- Used as the architectural register array of small datapath and processor labs.

Parameters:
DATA_W, 4, data width in bits (>=1)
DEPTH, 4, number of entries (>=2, need not be a power of 2)
ADDR_W, $clog2(DEPTH), address width (derived; do not override)
ZERO_REG0, 0, 1 = entry 0 reads as 0 with valid=1 and ignores writes

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write enable
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
clr  in  1  invalidate all entries (single cycle)
rd_en0  in  1  read-port-0 enable
rd_addr0  in  ADDR_W  read-port-0 address
rd_data0  out  DATA_W  read-port-0 data, registered
rd_valid0  out  1  valid flag of entry read on port 0, registered
rd_en1  in  1  read-port-1 enable
rd_addr1  in  ADDR_W  read-port-1 address
rd_data1  out  DATA_W  read-port-1 data, registered
rd_valid1  out  1  valid flag of entry read on port 1, registered

Behaviour:
- Reset (rst_n low, async): all valid flags 0; all storage words 0; rd_data0/1 = 0; rd_valid0/1 = 0. Takes effect immediately, including mid-write. The first edge after deassertion is a normal cycle.
- Write: on an edge with wr_en=1 and wr_addr < DEPTH, mem[wr_addr] <= wr_data and valid[wr_addr] <= 1.
  - wr_addr >= DEPTH: write ignored.
  - ZERO_REG0=1 and wr_addr=0: write ignored.
- clr: on an edge with clr=1, all valid flags are set to 0. Storage contents are unchanged.
  - clr and wr_en in the same cycle: clr applies first, then the write. The written entry ends valid; all others end invalid.
- Read (per port p, identical and independent):
  - On an edge with rd_en_p=1, rd_data_p/rd_valid_p load the state of entry rd_addr_p as it stands after this edge's clr/write updates. This is write-first bypass: a same-cycle write to the same address is returned.
  - Latency: 1 cycle from address to output.
  - rd_en_p=0: outputs hold their previous value.
  - Entry invalid: rd_data_p = 0, rd_valid_p = 0. Stale storage is never exposed.
  - rd_addr_p >= DEPTH: rd_data_p = 0, rd_valid_p = 0.
  - ZERO_REG0=1 and rd_addr_p = 0: rd_data_p = 0, rd_valid_p = 1, regardless of writes or clr.
- Both ports may read the same address, including the address being written, in the same cycle. Both return identical values.
- No stalls, no back-pressure. Every cycle accepts one write, one clr and two reads.

Decomposition:
- Shared package regfile_pkg holds:
  - ADDR_W derivation helper, a clog2 function with minimum result 1.
  - Zero constant for the read-miss data value.
- One sub-module: regfile_rd_port. It holds per-port output registers, bypass compare, range check and zero-reg override. Inputs are the array/valid snapshot plus the write/clr bus. It is instantiated twice.
- Storage and valid flags live in the top module.

Test Plan:
1. Reset then read (DATA_W=8, DEPTH=4): rd_en0=1, rd_addr0=2 -> next cycle rd_data0=0x00, rd_valid0=0.
2. Write 0xA5 to addr 1. Next cycle read addr 1 on both ports -> rd_data0=rd_data1=0xA5, rd_valid0=rd_valid1=1 one cycle after the read.
3. Bypass: same cycle wr_en=1, wr_addr=3, wr_data=0x3C, rd_addr1=3 -> rd_data1=0x3C, rd_valid1=1 on the following edge.
4. clr with a write to 2 (0x11) in the same cycle, after addrs 0-3 were written. Then read 1 and 2 -> addr 1: data 0, valid 0; addr 2: data 0x11, valid 1.
5. ZERO_REG0=1: write 0xFF to addr 0, then read addr 0 -> rd_data0=0x00, rd_valid0=1. Out-of-range with DEPTH=3: write addr 3, then read addr 3 -> data 0, valid 0, no entry changed.
6. Assert rst_n low mid-stream with rd_en held at 0 -> rd_data/rd_valid drop to 0 asynchronously. After release, reads of previously written entries return valid 0.
